// File: rtl/apb_bfm_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and default timeout.
package apb_bfm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 256;

endpackage : apb_bfm_pkg

// File: rtl/apb_requester.sv
// Avalon-MM style request port to APB requester bridge with a bounded wait on pready.
// One transfer in flight; the completion is reported one cycle after the APB handshake ends.
module apb_requester
    import apb_bfm_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 32,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
    parameter logic [2:0]  PPROT     = 3'b000
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic [ADDRWIDTH-1:0]     av_address,
    input  logic [DATAWIDTH/8-1:0]   av_byteenable,
    input  logic                     av_write,
    input  logic [DATAWIDTH-1:0]     av_writedata,
    input  logic                     av_read,
    output logic                     av_waitrequest,
    output logic [DATAWIDTH-1:0]     av_readdata,
    output logic                     av_readdatavalid,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDRWIDTH-1:0]     paddr,
    output logic [DATAWIDTH-1:0]     pwdata,
    output logic [DATAWIDTH/8-1:0]   pstrb,
    output logic [2:0]               pprot,
    input  logic [DATAWIDTH-1:0]     prdata,
    input  logic                     pready,
    input  logic                     pslverr
);

    localparam int unsigned STRBWIDTH = DATAWIDTH / 8;
    localparam int unsigned CNTWIDTH  = $clog2(TIMEOUT + 1);

    apb_state_e            state;
    apb_state_e            state_next;
    logic [CNTWIDTH-1:0]   tmo_cnt;
    logic [CNTWIDTH-1:0]   tmo_cnt_next;
    logic                  accept;
    logic                  done_ok;
    logic                  done_tmo;

    // State register and timeout counter
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_cnt_next;
        end
    end

    // Next state, timeout counting and completion decode
    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        accept       = 1'b0;
        done_ok      = 1'b0;
        done_tmo     = 1'b0;
        case (state)
            IDLE: begin
                if (av_read || av_write) begin
                    accept       = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    done_ok    = 1'b1;
                    state_next = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt + CNTWIDTH'(1);
                    // This cycle brings the count to TIMEOUT: give up
                    if (tmo_cnt == CNTWIDTH'(TIMEOUT - 1)) begin
                        done_tmo   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // APB phase controls follow the state being entered
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            psel    <= (state_next != IDLE);
            penable <= (state_next == ACCESS);
        end
    end

    // Request capture; the APB payload holds its last value while idle
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (accept) begin
            pwrite <= av_write;
            paddr  <= av_address;
            pwdata <= av_writedata;
            pstrb  <= av_write ? av_byteenable : STRBWIDTH'(0);
        end
    end

    // Completion reporting, one cycle after the handshake or timeout
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            resp_valid       <= 1'b0;
            resp_err         <= 1'b0;
            av_readdatavalid <= 1'b0;
            av_readdata      <= '0;
        end else begin
            resp_valid       <= done_ok | done_tmo;
            resp_err         <= done_tmo | (done_ok & pslverr);
            av_readdatavalid <= (done_ok | done_tmo) & ~pwrite;
            if (done_tmo) begin
                av_readdata <= '0;
            end else if (done_ok && !pwrite) begin
                av_readdata <= prdata;
            end
        end
    end

    assign av_waitrequest = (state != IDLE);
    assign pprot          = PPROT;

endmodule : apb_requester

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: APB completer with programmable wait states and
// error response, plus a transaction-level reference of memory contents and completion results.
module tb_apb_requester;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TMO     = 8;
    localparam logic [2:0]  PROT    = 3'b101;

    logic           pclk;
    logic           presetn;
    logic [AW-1:0]  av_address;
    logic [3:0]     av_byteenable;
    logic           av_write;
    logic [DW-1:0]  av_writedata;
    logic           av_read;
    logic           av_waitrequest;
    logic [DW-1:0]  av_readdata;
    logic           av_readdatavalid;
    logic           resp_valid;
    logic           resp_err;
    logic           psel;
    logic           penable;
    logic           pwrite;
    logic [AW-1:0]  paddr;
    logic [DW-1:0]  pwdata;
    logic [3:0]     pstrb;
    logic [2:0]     pprot;
    logic [DW-1:0]  prdata;
    logic           pready;
    logic           pslverr;

    int checks = 0;
    int errors = 0;

    apb_requester #(
        .ADDRWIDTH (AW),
        .DATAWIDTH (DW),
        .TIMEOUT   (TMO),
        .PPROT     (PROT)
    ) dut (
        .pclk             (pclk),
        .presetn          (presetn),
        .av_address       (av_address),
        .av_byteenable    (av_byteenable),
        .av_write         (av_write),
        .av_writedata     (av_writedata),
        .av_read          (av_read),
        .av_waitrequest   (av_waitrequest),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .resp_valid       (resp_valid),
        .resp_err         (resp_err),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .paddr            (paddr),
        .pwdata           (pwdata),
        .pstrb            (pstrb),
        .pprot            (pprot),
        .prdata           (prdata),
        .pready           (pready),
        .pslverr          (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Completer: 16-word memory at 0x1000, cur_waits low cycles before pready
    logic [DW-1:0] mem [16];
    logic [DW-1:0] ref_mem [16];
    int            cur_waits = 0;
    logic          cur_err   = 1'b0;
    int            acc_cnt   = 0;

    assign pready  = psel && penable && (acc_cnt >= cur_waits);
    assign prdata  = mem[paddr[5:2]];
    assign pslverr = pready && cur_err;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite && !cur_err) begin
            for (int b = 0; b < 4; b++)
                if (pstrb[b]) mem[paddr[5:2]][b*8 +: 8] <= pwdata[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction; starts and ends at a negedge with the requester idle
    task automatic do_txn(input logic wr, input logic rd, input logic [3:0] idx,
                          input logic [DW-1:0] data, input logic [3:0] be,
                          input int waits, input logic err);
        logic [AW-1:0] addr;
        logic          is_wr;
        logic          tmo;
        int            exp_acc;
        logic [DW-1:0] exp_data;
        int            n = 0;
        int            setup_n = 0;
        int            acc_n = 0;
        logic          bad = 1'b0;
        logic          done = 1'b0;
        logic          g_err = 1'b0;
        logic          g_rdv = 1'b0;
        logic [DW-1:0] g_data = '0;
        logic          g_psel = 1'b0;

        addr    = 32'h1000 + 32'(idx) * 4;
        is_wr   = wr;
        tmo     = (waits >= int'(TMO));
        exp_acc = tmo ? int'(TMO) : waits + 1;

        check("idle_waitreq", 64'(av_waitrequest), 64'(0));
        cur_waits     = waits;
        cur_err       = err;
        av_write      = wr;
        av_read       = rd;
        av_address    = addr;
        av_writedata  = data;
        av_byteenable = be;
        @(posedge pclk);
        #1;
        av_write = 1'b0;
        av_read  = 1'b0;
        av_writedata = $urandom;

        while (!done && n < 40) begin
            @(negedge pclk);
            n++;
            if (resp_valid) begin
                done   = 1'b1;
                g_err  = resp_err;
                g_rdv  = av_readdatavalid;
                g_data = av_readdata;
                g_psel = psel;
            end else begin
                if (psel && !penable) setup_n++;
                if (psel && penable)  acc_n++;
                if (!av_waitrequest) bad = 1'b1;
            end
            if (psel) begin
                if (paddr !== addr || pwrite !== is_wr || pprot !== PROT) bad = 1'b1;
                if (pstrb !== (is_wr ? be : 4'h0)) bad = 1'b1;
                if (is_wr && pwdata !== data) bad = 1'b1;
            end
        end

        // Reference: writes land on normal, error-free completion; reads return memory or 0
        exp_data = tmo ? '0 : ref_mem[idx];
        if (is_wr && !tmo && !err)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];

        check("resp_seen",  64'(done),    64'(1));
        check("setup_cyc",  64'(setup_n), 64'(1));
        check("access_cyc", 64'(acc_n),   64'(exp_acc));
        check("latency",    64'(n),       64'(exp_acc + 2));
        check("held_apb",   64'(bad),     64'(0));
        check("psel_resp",  64'(g_psel),  64'(0));
        check("resp_err",   64'(g_err),   64'(tmo | err));
        check("rdvalid",    64'(g_rdv),   64'(!is_wr));
        if (!is_wr) check("rdata", 64'(g_data), 64'(exp_data));
    endtask

    initial begin
        logic [DW-1:0] seed_word;
        presetn       = 1'b0;
        av_address    = '0;
        av_byteenable = '0;
        av_write      = 1'b0;
        av_writedata  = '0;
        av_read       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            seed_word  = $urandom;
            mem[i]     = seed_word;
            ref_mem[i] = seed_word;
        end

        #12;
        check("rst_psel",    64'(psel),             64'(0));
        check("rst_penable", 64'(penable),          64'(0));
        check("rst_pwrite",  64'(pwrite),           64'(0));
        check("rst_paddr",   64'(paddr),            64'(0));
        check("rst_pwdata",  64'(pwdata),           64'(0));
        check("rst_pstrb",   64'(pstrb),            64'(0));
        check("rst_rdata",   64'(av_readdata),      64'(0));
        check("rst_rdv",     64'(av_readdatavalid), 64'(0));
        check("rst_resp",    64'(resp_valid),       64'(0));
        check("rst_err",     64'(resp_err),         64'(0));
        check("rst_waitreq", 64'(av_waitrequest),   64'(0));
        check("pprot",       64'(pprot),            64'(PROT));

        @(negedge pclk);
        presetn = 1'b1;

        // Directed: zero-wait write/read-back, long wait, timeout, pready on last cycle, slave error
        do_txn(1'b1, 1'b0, 4'd0, 32'hA5A5_5A5A, 4'hF, 0, 1'b0);
        do_txn(1'b0, 1'b1, 4'd0, 32'h0,         4'hF, 0, 1'b0);
        do_txn(1'b0, 1'b1, 4'd0, 32'h0,         4'h0, 5, 1'b0);
        do_txn(1'b0, 1'b1, 4'd1, 32'h0,         4'h0, 1000, 1'b0);
        do_txn(1'b1, 1'b0, 4'd2, 32'h1234_5678, 4'hF, 1000, 1'b0);
        do_txn(1'b0, 1'b1, 4'd2, 32'h0,         4'h0, int'(TMO) - 1, 1'b0);
        do_txn(1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF, 4'hF, 0, 1'b1);
        do_txn(1'b0, 1'b1, 4'd3, 32'h0,         4'h0, 0, 1'b0);
        do_txn(1'b1, 1'b1, 4'd4, 32'hCAFE_F00D, 4'h5, 1, 1'b0);
        do_txn(1'b0, 1'b1, 4'd4, 32'h0,         4'h0, 0, 1'b0);

        // Reset during ACCESS abandons the transfer
        cur_waits  = 1000;
        cur_err    = 1'b0;
        av_write   = 1'b1;
        av_address = 32'h1000 + 32'd20;
        av_writedata  = 32'h0BAD_0BAD;
        av_byteenable = 4'hF;
        @(posedge pclk);
        #1;
        av_write = 1'b0;
        for (int i = 0; i < 10 && !(psel && penable); i++) @(negedge pclk);
        check("pre_rst_access", 64'(psel && penable), 64'(1));
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        check("arst_psel",    64'(psel),       64'(0));
        check("arst_penable", 64'(penable),    64'(0));
        check("arst_resp",    64'(resp_valid), 64'(0));
        @(negedge pclk);
        presetn = 1'b1;
        check("post_rst_resp", 64'(resp_valid), 64'(0));
        do_txn(1'b0, 1'b1, 4'd5, 32'h0, 4'h0, 0, 1'b0);

        // Randomized back-to-back traffic
        for (int t = 0; t < 60; t++) begin
            logic          wr;
            logic          rd;
            int            w;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            case ($urandom_range(0, 5))
                0:       w = int'(TMO) + $urandom_range(0, 3);
                1:       w = int'(TMO) - 1;
                default: w = $urandom_range(0, 4);
            endcase
            do_txn(wr, rd, 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                   w, ($urandom_range(0, 5) == 0));
        end

        @(negedge pclk);
        check("no_extra_resp", 64'(resp_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_requester
